// File: rtl/rram_ctrl_pkg.sv
// Shared types and defaults for the RRAM write-verify controller.
// Widths here are defaults only; the controller is parameterised.
package rram_ctrl_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 6;
  localparam int MAX_TRIES_DEF = 4;
  localparam int TRY_W         = 3;
  localparam int CNT_W         = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    VRD  = 3'd2,
    VCMP = 3'd3,
    RD   = 3'd4,
    RCAP = 3'd5,
    DONE = 3'd6
  } state_t;

  function automatic logic macro_active(
    input state_t s
  );
    return (s == WR) || (s == VRD) || (s == RD);
  endfunction

endpackage

// File: rtl/rram_wv_ctrl.sv
// Write-verify / read controller for a single-port RRAM macro.
// Macro pins come straight from flops so they never glitch.
module rram_wv_ctrl
  import rram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int MAX_TRIES  = MAX_TRIES_DEF
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_fail,
  output logic [2:0]            rsp_tries,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0
);

  state_t           state;
  state_t           nxt;
  logic [TRY_W-1:0] tries;
  logic             accept;
  logic             match;
  logic             last_try;
  logic             fail_now;

  assign accept   = req_valid && req_ready;
  assign match    = (mem_dout0 == mem_din0);
  assign last_try = (tries == TRY_W'(MAX_TRIES));
  assign fail_now = (state == VCMP) && !match;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          nxt = req_we ? WR : RD;
        end
      end
      WR:   nxt = VRD;
      VRD:  nxt = VCMP;
      VCMP: begin
        if (match || last_try) begin
          nxt = DONE;
        end else begin
          nxt = WR;
        end
      end
      RD:   nxt = RCAP;
      RCAP: nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Macro strobes are decoded from the next state into flops
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      mem_csb0  <= 1'b1;
      mem_web0  <= 1'b1;
      mem_addr0 <= '0;
      mem_din0  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= (nxt == IDLE);
      mem_csb0  <= !macro_active(nxt);
      mem_web0  <= (nxt != WR);
      rsp_valid <= (nxt == DONE);
      if (accept) begin
        mem_addr0 <= req_addr;
        mem_din0  <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      tries <= '0;
    end else if (accept) begin
      tries <= '0;
    end else if (state == WR) begin
      tries <= tries + TRY_W'(1);
    end
  end

  // Read data is only legal at the edge closing VCMP/RCAP
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_fail  <= 1'b0;
      rsp_tries <= '0;
    end else begin
      if ((state == VCMP) || (state == RCAP)) begin
        rsp_rdata <= mem_dout0;
      end
      if (nxt == DONE) begin
        rsp_fail  <= fail_now;
        rsp_tries <= (state == VCMP) ? tries : '0;
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= '0;
    end else if ((nxt == DONE) && fail_now) begin
      if (fail_cnt != {CNT_W{1'b1}}) begin
        fail_cnt <= fail_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rram_wv_ctrl.sv
// Directed bench for rram_wv_ctrl with a behavioural macro model.
// Expected responses are queued at issue time and popped on rsp_valid.
module tb_rram_wv_ctrl;
  import rram_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int MT = 4;

  logic          clk0 = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_fail;
  logic [2:0]    rsp_tries;
  logic [7:0]    fail_cnt;
  logic          mem_csb0;
  logic          mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] mem_din0;
  logic [DW-1:0] mem_dout0 = 'x;

  always #5 clk0 = ~clk0;

  rram_wv_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_TRIES (MT)
  ) dut (
    .clk0      (clk0),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_fail  (rsp_fail),
    .rsp_tries (rsp_tries),
    .fail_cnt  (fail_cnt),
    .mem_csb0  (mem_csb0),
    .mem_web0  (mem_web0),
    .mem_addr0 (mem_addr0),
    .mem_din0  (mem_din0),
    .mem_dout0 (mem_dout0)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          fail;
    logic [2:0]    tries;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   passes = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   rsps = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, expv);
  endtask

  // Macro model: faulty word 0x10 reads 0, 0x3F flips bit 0 twice
  logic [DW-1:0] mem [64];
  int            wr3f = 0;
  int            wr10 = 0;
  logic          s_csb = 1'b1;
  logic          s_web = 1'b1;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_din = '0;
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
  end

  always @(posedge clk0) begin
    rd_pend = 1'b0;
    if (rst_n && !s_csb) begin
      if (!s_web) begin
        if (s_addr == 6'h3F && wr3f < 2) begin
          mem[s_addr] = s_din ^ 16'h0001;
          wr3f++;
        end else begin
          mem[s_addr] = s_din;
        end
        if (s_addr == 6'h10) wr10++;
      end else begin
        rd_pend = 1'b1;
        rd_addr = s_addr;
      end
    end
  end

  always @(negedge clk0) begin
    if (rd_pend) begin
      mem_dout0 = (rd_addr == 6'h10) ? '0 : mem[rd_addr];
    end else begin
      mem_dout0 = 'x;
    end
    s_csb  = mem_csb0;
    s_web  = mem_web0;
    s_addr = mem_addr0;
    s_din  = mem_din0;
  end

  // Reference of what the controller should report
  logic [DW-1:0] emem [64];
  int            e3f = 0;
  int            efail = 0;

  initial begin
    for (int i = 0; i < 64; i++) emem[i] = '0;
  end

  function automatic exp_t exp_write(input logic [AW-1:0] a,
                                     input logic [DW-1:0] d);
    exp_t          r;
    logic [DW-1:0] st;
    logic [DW-1:0] rb;
    r.rdata = '0;
    r.fail  = 1'b0;
    r.tries = '0;
    r.lat   = 0;
    for (int t = 1; t <= MT; t++) begin
      st = d;
      if (a == 6'h3F && e3f < 2) begin
        st = d ^ 16'h0001;
        e3f++;
      end
      emem[a] = st;
      rb = (a == 6'h10) ? '0 : st;
      r.rdata = rb;
      r.tries = 3'(t);
      r.lat   = 1 + 3 * t;
      r.fail  = (rb != d);
      if (rb == d) return r;
    end
    efail = (efail < 255) ? efail + 1 : 255;
    return r;
  endfunction

  function automatic exp_t exp_read(input logic [AW-1:0] a);
    exp_t r;
    r.rdata = (a == 6'h10) ? '0 : emem[a];
    r.fail  = 1'b0;
    r.tries = '0;
    r.lat   = 3;
    return r;
  endfunction

  exp_t me;
  int   ma;

  always @(negedge clk0) begin
    cyc++;
    if (!rst_n) begin
      acc_q.delete();
    end else begin
      if (rsp_valid) begin
        rsps++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("spurious_rsp", 32'd1, 32'd0);
        end else begin
          me = exp_q.pop_front();
          ma = acc_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(me.rdata));
          check("rsp_fail", 32'(rsp_fail), 32'(me.fail));
          check("rsp_tries", 32'(rsp_tries), 32'(me.tries));
          check("latency", 32'(cyc - ma), 32'(me.lat));
        end
      end
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc);
        accepts++;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk0);
      if (req_ready) break;
      n++;
      if (n > 100) begin
        check("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic issue(input logic          we,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input bit            push);
    @(posedge clk0);
    #2;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    if (push) exp_q.push_back(we ? exp_write(a, d) : exp_read(a));
    wait_ready();
    @(posedge clk0);
    #2;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~a;
    req_wdata = ~d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk0);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  int            p0;
  int            a0;
  logic [DW-1:0] pat;

  initial begin
    #12;
    check("rst_csb", 32'(mem_csb0), 32'd1);
    check("rst_web", 32'(mem_web0), 32'd1);
    check("rst_addr", 32'(mem_addr0), 32'd0);
    check("rst_din", 32'(mem_din0), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp", {rsp_rdata, 12'd0, rsp_fail, rsp_tries}, 32'd0);
    check("rst_fcnt", 32'(fail_cnt), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk0);
    rst_n = 1'b1;

    issue(1'b1, 6'h05, 16'hA5A5, 1'b1);
    check("busy_ready", 32'(req_ready), 32'd0);
    drain();
    issue(1'b0, 6'h05, 16'h0000, 1'b1);
    drain();
    issue(1'b1, 6'h3F, 16'h0001, 1'b1);
    drain();
    p0 = wr10;
    issue(1'b1, 6'h10, 16'hFFFF, 1'b1);
    drain();
    check("wr_pulses", 32'(wr10 - p0), 32'd4);
    check("fail_cnt1", 32'(fail_cnt), 32'(efail));

    issue(1'b1, 6'h22, 16'h1234, 1'b0);
    p0 = 0;
    while (!(mem_csb0 == 1'b0 && mem_web0 == 1'b1) && p0 < 10) begin
      @(negedge clk0);
      p0++;
    end
    check("in_vrd", 32'(mem_web0 && !mem_csb0), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_csb", 32'(mem_csb0), 32'd1);
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    efail = 0;
    repeat (2) @(negedge clk0);
    rst_n = 1'b1;
    check("rst_mid_fcnt", 32'(fail_cnt), 32'd0);
    issue(1'b0, 6'h05, 16'h0000, 1'b1);
    drain();

    for (int i = 0; i < 64; i++) begin
      pat = 16'(i * 16'h0101) ^ 16'hC3A5;
      issue(1'b1, 6'(i), pat, 1'b1);
    end
    drain();
    check("fail_cnt2", 32'(fail_cnt), 32'(efail));

    @(posedge clk0);
    #2;
    a0 = accepts;
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      req_addr = 6'(i);
      exp_q.push_back(exp_read(6'(i)));
      wait_ready();
      @(posedge clk0);
      #2;
    end
    req_valid = 1'b0;
    drain();
    check("held_accepts", 32'(accepts - a0), 32'd64);
    check("rsp_count", 32'(rsps), 32'(accepts - 1));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
